// File: rtl/sb_ctrl_regs.sv
// -----------------------------------------------------------------------------
// sb_ctrl_regs
//
// Front end of the debug module's system bus access engine. Decodes DMI
// requests to sbcs, sbaddress0 and sbdata0, holds their architectural state,
// and hands the bus engine registered one-cycle strobes plus the static sbcs
// controls. Bus read data returned by the engine is captured into sbdata0, and
// sbaddress0 is advanced by sbautoincrement when an access completes.
//
// Ports:
//   sys_clk, sys_rstn            clock, synchronous active-low reset
//   dmi_req_*                    one-cycle DMI request (op 1 = read, 2 = write)
//   dmi_rsp_valid/rdata          response, one cycle after a decoded request
//   sbaddress0, sbdata0          current register values
//   sbaddress0_update            pulse: DMI wrote sbaddress0
//   sbdata0_update               pulse: DMI wrote sbdata0
//   sbdata0_rd                   pulse: DMI read sbdata0 with sbreadondata set
//   sbreadonaddr/sbaccess/
//   sbreadondata                 static sbcs controls
//   sberror_w1, sbbusyerror_w1   pulses: write-1-to-clear bits for the engine
//   system_bus_read_data(_valid) read data returned by the engine
//   sbbusy, sberror, sbbusyerror engine status
// -----------------------------------------------------------------------------
module sb_ctrl_regs #(
    parameter int          SBASIZE      = 32,
    parameter logic [6:0]  SB_ADDR_BASE = 7'h38
) (
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic        dmi_req_valid,
    input  logic [6:0]  dmi_req_addr,
    input  logic [1:0]  dmi_req_op,
    input  logic [31:0] dmi_req_wdata,
    output logic        dmi_rsp_valid,
    output logic [31:0] dmi_rsp_rdata,
    output logic [31:0] sbaddress0,
    output logic        sbaddress0_update,
    output logic [31:0] sbdata0,
    output logic        sbdata0_update,
    output logic        sbdata0_rd,
    output logic        sbreadonaddr,
    output logic [2:0]  sbaccess,
    output logic        sbreadondata,
    output logic [2:0]  sberror_w1,
    output logic        sbbusyerror_w1,
    input  logic [31:0] system_bus_read_data,
    input  logic        system_bus_read_data_valid,
    input  logic        sbbusy,
    input  logic [2:0]  sberror,
    input  logic        sbbusyerror
);

    localparam logic [6:0] ADDR_SBCS    = SB_ADDR_BASE;
    localparam logic [6:0] ADDR_SBADDR0 = SB_ADDR_BASE + 7'd1;
    localparam logic [6:0] ADDR_SBDATA0 = SB_ADDR_BASE + 7'd4;
    localparam logic [1:0] OP_READ      = 2'd1;
    localparam logic [1:0] OP_WRITE     = 2'd2;
    localparam logic [6:0] SBASIZE_FIELD = SBASIZE[6:0];

    logic        sbautoincrement;
    logic        sbbusy_d;

    logic        req_ok;
    logic        is_rd;
    logic        is_wr;
    logic        sel_sbcs;
    logic        sel_addr;
    logic        sel_data;
    logic        hit;
    logic        access_ok;
    logic        access_done;
    logic [31:0] sbcs_value;
    logic [31:0] rdata_next;

    assign is_rd    = (dmi_req_op == OP_READ);
    assign is_wr    = (dmi_req_op == OP_WRITE);
    assign req_ok   = dmi_req_valid && (is_rd || is_wr);
    assign sel_sbcs = req_ok && (dmi_req_addr == ADDR_SBCS);
    assign sel_addr = req_ok && (dmi_req_addr == ADDR_SBADDR0);
    assign sel_data = req_ok && (dmi_req_addr == ADDR_SBDATA0);
    assign hit      = sel_sbcs || sel_addr || sel_data;

    // sbaddress0/sbdata0 may only change while the engine is idle and clean;
    // strobes still go out so the engine can flag a busy error.
    assign access_ok   = !sbbusy && !sbbusyerror && (sberror == 3'd0);
    assign access_done = sbbusy_d && !sbbusy;

    assign sbcs_value = {3'd1, 6'd0, sbbusyerror, sbbusy, sbreadonaddr, sbaccess,
                         sbautoincrement, sbreadondata, sberror, SBASIZE_FIELD,
                         5'b00111};

    always_comb begin
        // NOTE: default assignment first so no path leaves rdata_next unassigned (no latch).
        rdata_next = 32'd0;
        if (is_rd) begin
            if (sel_sbcs)      rdata_next = sbcs_value;
            else if (sel_addr) rdata_next = sbaddress0;
            else if (sel_data) rdata_next = sbdata0;
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: every state bit is reset here; there is no memory array to leave unreset.
        if (!sys_rstn) begin
            dmi_rsp_valid     <= 1'b0;
            dmi_rsp_rdata     <= 32'd0;
            sbaddress0        <= 32'd0;
            sbdata0           <= 32'd0;
            sbreadonaddr      <= 1'b0;
            sbaccess          <= 3'd2;
            sbautoincrement   <= 1'b0;
            sbreadondata      <= 1'b0;
            sbaddress0_update <= 1'b0;
            sbdata0_update    <= 1'b0;
            sbdata0_rd        <= 1'b0;
            sberror_w1        <= 3'd0;
            sbbusyerror_w1    <= 1'b0;
            sbbusy_d          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all reads above see pre-edge values.
            dmi_rsp_valid     <= hit;
            dmi_rsp_rdata     <= rdata_next;
            sbaddress0_update <= sel_addr && is_wr;
            sbdata0_update    <= sel_data && is_wr;
            sbdata0_rd        <= sel_data && is_rd && sbreadondata && access_ok;
            sberror_w1        <= (sel_sbcs && is_wr) ? dmi_req_wdata[14:12] : 3'd0;
            sbbusyerror_w1    <= sel_sbcs && is_wr && dmi_req_wdata[22];
            sbbusy_d          <= sbbusy;

            if (sel_sbcs && is_wr) begin
                sbreadonaddr    <= dmi_req_wdata[20];
                sbaccess        <= dmi_req_wdata[19:17];
                sbautoincrement <= dmi_req_wdata[16];
                sbreadondata    <= dmi_req_wdata[15];
            end

            // An accepted DMI write overrides the post-access increment.
            if (sel_addr && is_wr && access_ok)
                sbaddress0 <= dmi_req_wdata;
            else if (access_done && sbautoincrement && (sberror == 3'd0))
                sbaddress0 <= sbaddress0 + (32'd1 << sbaccess);

            // Returned bus data overrides a same-cycle DMI write.
            if (system_bus_read_data_valid)
                sbdata0 <= system_bus_read_data;
            else if (sel_data && is_wr && access_ok)
                sbdata0 <= dmi_req_wdata;
        end
    end

endmodule

// File: tb/tb_sb_ctrl_regs.sv
module tb_sb_ctrl_regs;

    localparam logic [6:0] BASE = 7'h38;

    logic        sys_clk = 1'b0;
    logic        sys_rstn;
    logic        dmi_req_valid;
    logic [6:0]  dmi_req_addr;
    logic [1:0]  dmi_req_op;
    logic [31:0] dmi_req_wdata;
    logic        dmi_rsp_valid;
    logic [31:0] dmi_rsp_rdata;
    logic [31:0] sbaddress0;
    logic        sbaddress0_update;
    logic [31:0] sbdata0;
    logic        sbdata0_update;
    logic        sbdata0_rd;
    logic        sbreadonaddr;
    logic [2:0]  sbaccess;
    logic        sbreadondata;
    logic [2:0]  sberror_w1;
    logic        sbbusyerror_w1;
    logic [31:0] system_bus_read_data;
    logic        system_bus_read_data_valid;
    logic        sbbusy;
    logic [2:0]  sberror;
    logic        sbbusyerror;

    int n_checks = 0;
    int n_errors = 0;

    sb_ctrl_regs #(.SBASIZE(32), .SB_ADDR_BASE(BASE)) dut (
        .sys_clk                    (sys_clk),
        .sys_rstn                   (sys_rstn),
        .dmi_req_valid              (dmi_req_valid),
        .dmi_req_addr               (dmi_req_addr),
        .dmi_req_op                 (dmi_req_op),
        .dmi_req_wdata              (dmi_req_wdata),
        .dmi_rsp_valid              (dmi_rsp_valid),
        .dmi_rsp_rdata              (dmi_rsp_rdata),
        .sbaddress0                 (sbaddress0),
        .sbaddress0_update          (sbaddress0_update),
        .sbdata0                    (sbdata0),
        .sbdata0_update             (sbdata0_update),
        .sbdata0_rd                 (sbdata0_rd),
        .sbreadonaddr               (sbreadonaddr),
        .sbaccess                   (sbaccess),
        .sbreadondata               (sbreadondata),
        .sberror_w1                 (sberror_w1),
        .sbbusyerror_w1             (sbbusyerror_w1),
        .system_bus_read_data       (system_bus_read_data),
        .system_bus_read_data_valid (system_bus_read_data_valid),
        .sbbusy                     (sbbusy),
        .sberror                    (sberror),
        .sbbusyerror                (sbbusyerror)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model (architectural view) ----------------
    logic [31:0] m_addr, m_data, m_rdata;
    logic        m_roa, m_autoinc, m_rod, m_prev_busy;
    logic [2:0]  m_access, m_err_w1;
    logic        m_rsp, m_addr_upd, m_data_upd, m_data_rd, m_be_w1;

    task automatic model_reset();
        m_addr = 0; m_data = 0; m_rdata = 0; m_roa = 0; m_autoinc = 0; m_rod = 0;
        m_prev_busy = 0; m_access = 3'd2; m_err_w1 = 0; m_rsp = 0;
        m_addr_upd = 0; m_data_upd = 0; m_data_rd = 0; m_be_w1 = 0;
    endtask

    // Advance one clock: the model computes its next state from the inputs
    // held stable before the edge, then commits after the edge.
    task automatic tick();
        logic [31:0] n_addr, n_data, n_rdata, sbcs_val;
        logic        n_roa, n_autoinc, n_rod, n_rsp, n_aupd, n_dupd, n_drd, n_bew1;
        logic [2:0]  n_access, n_errw1;
        bit          is_reg, good_op, req, idle_clean, is_wr, is_rd;
        is_reg  = (dmi_req_addr == BASE) || (dmi_req_addr == BASE + 7'd1) ||
                  (dmi_req_addr == BASE + 7'd4);
        good_op = (dmi_req_op == 2'd1) || (dmi_req_op == 2'd2);
        req     = dmi_req_valid && is_reg && good_op;
        is_wr   = req && dmi_req_op == 2'd2;
        is_rd   = req && dmi_req_op == 2'd1;
        idle_clean = !sbbusy && !sbbusyerror && sberror == 0;
        sbcs_val = 32'h2000_0000 + (32'(sbbusyerror) << 22) + (32'(sbbusy) << 21) +
                   (32'(m_roa) << 20) + (32'(m_access) << 17) + (32'(m_autoinc) << 16) +
                   (32'(m_rod) << 15) + (32'(sberror) << 12) + (32 << 5) + 7;
        n_rsp = req;
        n_rdata = 0;
        if (is_rd) begin
            if (dmi_req_addr == BASE)              n_rdata = sbcs_val;
            else if (dmi_req_addr == BASE + 7'd1)  n_rdata = m_addr;
            else                                   n_rdata = m_data;
        end
        n_aupd = is_wr && dmi_req_addr == BASE + 7'd1;
        n_dupd = is_wr && dmi_req_addr == BASE + 7'd4;
        n_drd  = is_rd && dmi_req_addr == BASE + 7'd4 && m_rod && idle_clean;
        n_errw1 = (is_wr && dmi_req_addr == BASE) ? dmi_req_wdata[14:12] : 3'd0;
        n_bew1  = is_wr && dmi_req_addr == BASE && dmi_req_wdata[22];
        n_roa = m_roa; n_access = m_access; n_autoinc = m_autoinc; n_rod = m_rod;
        if (is_wr && dmi_req_addr == BASE) begin
            n_roa = dmi_req_wdata[20]; n_access = dmi_req_wdata[19:17];
            n_autoinc = dmi_req_wdata[16]; n_rod = dmi_req_wdata[15];
        end
        n_addr = m_addr;
        if (m_prev_busy && !sbbusy && m_autoinc && sberror == 0)
            n_addr = m_addr + (2 ** m_access);
        if (n_aupd && idle_clean) n_addr = dmi_req_wdata;
        n_data = m_data;
        if (n_dupd && idle_clean) n_data = dmi_req_wdata;
        if (system_bus_read_data_valid) n_data = system_bus_read_data;
        @(posedge sys_clk);
        #1;
        if (!sys_rstn) begin
            model_reset();
        end else begin
            m_addr = n_addr; m_data = n_data; m_rdata = n_rdata; m_roa = n_roa;
            m_access = n_access; m_autoinc = n_autoinc; m_rod = n_rod;
            m_prev_busy = sbbusy; m_rsp = n_rsp; m_addr_upd = n_aupd;
            m_data_upd = n_dupd; m_data_rd = n_drd; m_err_w1 = n_errw1; m_be_w1 = n_bew1;
        end
    endtask

    // One DMI request cycle; on return the response cycle is visible.
    task automatic dmi(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] wdata);
        dmi_req_valid = 1; dmi_req_addr = addr; dmi_req_op = op; dmi_req_wdata = wdata;
        tick();
        dmi_req_valid = 0; dmi_req_op = 0; dmi_req_wdata = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sys_rstn = 0;
        tick();
        tick();
        n_checks++;
        if ({dmi_rsp_valid, sbaddress0_update, sbdata0_update, sbdata0_rd, sbbusyerror_w1,
             sbreadonaddr, sbreadondata} !== 7'd0 || sberror_w1 !== 3'd0) begin
            n_errors++; $display("FAIL reset_flags: got nonzero strobe/flag, required all 0");
        end
        n_checks++;
        if (sbaddress0 !== 32'd0 || sbdata0 !== 32'd0 || dmi_rsp_rdata !== 32'd0) begin
            n_errors++; $display("FAIL reset_regs: got %h/%h/%h required 0/0/0",
                                 sbaddress0, sbdata0, dmi_rsp_rdata);
        end
        n_checks++;
        if (sbaccess !== 3'd2) begin
            n_errors++; $display("FAIL reset_sbaccess: got %0d required 2", sbaccess);
        end
        sys_rstn = 1;
        tick();
    endtask

    task automatic test_sbcs_read();
        dmi(BASE, 2'd1, 32'd0);
        n_checks++;
        if (dmi_rsp_valid !== 1'b1 || dmi_rsp_rdata !== 32'h2004_0407) begin
            n_errors++; $display("FAIL sbcs_read: got v=%b %h required v=1 20040407",
                                 dmi_rsp_valid, dmi_rsp_rdata);
        end
        tick();
        n_checks++;
        if (dmi_rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL rsp_one_cycle: got %b required 0", dmi_rsp_valid);
        end
        dmi(BASE + 7'd2, 2'd1, 32'd0);
        n_checks++;
        if (dmi_rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL nonhit_addr: got rsp %b required 0", dmi_rsp_valid);
        end
    endtask

    task automatic test_sbaddress_write();
        dmi(BASE + 7'd1, 2'd2, 32'h1000);
        n_checks++;
        if (sbaddress0 !== 32'h1000 || sbaddress0_update !== 1'b1 ||
            dmi_rsp_valid !== 1'b1 || dmi_rsp_rdata !== 32'd0) begin
            n_errors++; $display("FAIL addr_write: got a=%h upd=%b v=%b d=%h required 1000 1 1 0",
                                 sbaddress0, sbaddress0_update, dmi_rsp_valid, dmi_rsp_rdata);
        end
        tick();
        n_checks++;
        if (sbaddress0_update !== 1'b0) begin
            n_errors++; $display("FAIL addr_update_pulse: got %b required 0", sbaddress0_update);
        end
    endtask

    task automatic test_read_capture_autoinc();
        dmi(BASE, 2'd2, (32'd1 << 15) | (32'd1 << 16) | (32'd2 << 17));
        sbbusy = 1;
        tick();
        system_bus_read_data = 32'hDEAD_BEEF; system_bus_read_data_valid = 1;
        tick();
        system_bus_read_data_valid = 0; sbbusy = 0;
        tick();
        n_checks++;
        if (sbdata0 !== 32'hDEAD_BEEF || sbaddress0 !== 32'h1004) begin
            n_errors++; $display("FAIL capture_autoinc: got d=%h a=%h required deadbeef 1004",
                                 sbdata0, sbaddress0);
        end
        dmi(BASE + 7'd4, 2'd1, 32'd0);
        n_checks++;
        if (dmi_rsp_rdata !== 32'hDEAD_BEEF || sbdata0_rd !== 1'b1) begin
            n_errors++; $display("FAIL data_read: got %h rd=%b required deadbeef rd=1",
                                 dmi_rsp_rdata, sbdata0_rd);
        end
    endtask

    task automatic test_busy_gating();
        sbbusy = 1;
        tick();
        dmi(BASE + 7'd4, 2'd2, 32'h55);
        n_checks++;
        if (sbdata0_update !== 1'b1 || sbdata0 !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL busy_write: got upd=%b d=%h required 1 deadbeef",
                                 sbdata0_update, sbdata0);
        end
        dmi(BASE, 2'd2, (32'd1 << 22) | (32'd5 << 12));
        n_checks++;
        if (sbbusyerror_w1 !== 1'b1 || sberror_w1 !== 3'd5) begin
            n_errors++; $display("FAIL w1c: got be=%b err=%0d required 1 5",
                                 sbbusyerror_w1, sberror_w1);
        end
        tick();
        n_checks++;
        if (sbbusyerror_w1 !== 1'b0 || sberror_w1 !== 3'd0) begin
            n_errors++; $display("FAIL w1c_pulse: got be=%b err=%0d required 0 0",
                                 sbbusyerror_w1, sberror_w1);
        end
        sbbusy = 0;
        tick();
    endtask

    task automatic test_wrap();
        dmi(BASE, 2'd2, 32'd1 << 16);
        dmi(BASE + 7'd1, 2'd2, 32'hFFFF_FFFF);
        sbbusy = 1;
        tick();
        sbbusy = 0;
        tick();
        n_checks++;
        if (sbaddress0 !== 32'd0) begin
            n_errors++; $display("FAIL addr_wrap: got %h required 00000000", sbaddress0);
        end
        dmi(BASE, 2'd2, 32'd7 << 17);
        dmi(BASE, 2'd1, 32'd0);
        n_checks++;
        if (sbaccess !== 3'd7 || dmi_rsp_rdata !== 32'h200E_0407) begin
            n_errors++; $display("FAIL sbaccess7: got %0d rdata %h required 7 200e0407",
                                 sbaccess, dmi_rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        dmi(BASE + 7'd1, 2'd2, 32'hABCD_0000);
        sbbusy = 1; system_bus_read_data = 32'h1234_5678; system_bus_read_data_valid = 1;
        dmi_req_valid = 1; dmi_req_addr = BASE + 7'd4; dmi_req_op = 2'd1;
        sys_rstn = 0;
        tick();
        dmi_req_valid = 0; system_bus_read_data_valid = 0; sbbusy = 0;
        n_checks++;
        if (sbdata0 !== 32'd0 || sbaddress0 !== 32'd0 || dmi_rsp_valid !== 1'b0 ||
            sbdata0_rd !== 1'b0 || sbaccess !== 3'd2) begin
            n_errors++; $display("FAIL reset_mid_access: got d=%h a=%h v=%b rd=%b acc=%0d required 0 0 0 0 2",
                                 sbdata0, sbaddress0, dmi_rsp_valid, sbdata0_rd, sbaccess);
        end
        sys_rstn = 1;
        tick();
    endtask

    task automatic test_random();
        logic [6:0] addrs [4];
        addrs[0] = BASE; addrs[1] = BASE + 7'd1; addrs[2] = BASE + 7'd4; addrs[3] = 7'h00;
        for (int i = 0; i < 3000; i++) begin
            sys_rstn      = ($urandom_range(0, 199) != 0);
            dmi_req_valid = $urandom_range(0, 1);
            dmi_req_addr  = addrs[$urandom_range(0, 3)];
            if (dmi_req_addr == 7'h00) dmi_req_addr = 7'($urandom);
            dmi_req_op    = 2'($urandom);
            dmi_req_wdata = $urandom;
            system_bus_read_data       = $urandom;
            system_bus_read_data_valid = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) sbbusy = ~sbbusy;
            sberror     = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
            sbbusyerror = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++;
            if (dmi_rsp_valid !== m_rsp || dmi_rsp_rdata !== m_rdata) begin
                n_errors++; $display("FAIL rnd_rsp[%0d]: got %b/%h required %b/%h",
                                     i, dmi_rsp_valid, dmi_rsp_rdata, m_rsp, m_rdata);
            end
            n_checks++;
            if (sbaddress0 !== m_addr || sbdata0 !== m_data) begin
                n_errors++; $display("FAIL rnd_regs[%0d]: got %h/%h required %h/%h",
                                     i, sbaddress0, sbdata0, m_addr, m_data);
            end
            n_checks++;
            if ({sbaddress0_update, sbdata0_update, sbdata0_rd, sbbusyerror_w1, sberror_w1} !==
                {m_addr_upd, m_data_upd, m_data_rd, m_be_w1, m_err_w1}) begin
                n_errors++; $display("FAIL rnd_strobes[%0d]: got %b%b%b%b%03b required %b%b%b%b%03b",
                                     i, sbaddress0_update, sbdata0_update, sbdata0_rd, sbbusyerror_w1,
                                     sberror_w1, m_addr_upd, m_data_upd, m_data_rd, m_be_w1, m_err_w1);
            end
            n_checks++;
            if ({sbreadonaddr, sbaccess, sbreadondata} !== {m_roa, m_access, m_rod}) begin
                n_errors++; $display("FAIL rnd_ctrl[%0d]: got %b/%0d/%b required %b/%0d/%b",
                                     i, sbreadonaddr, sbaccess, sbreadondata, m_roa, m_access, m_rod);
            end
        end
        sys_rstn = 1; dmi_req_valid = 0; system_bus_read_data_valid = 0;
        sbbusy = 0; sberror = 0; sbbusyerror = 0;
        tick();
    endtask

    initial begin
        sys_rstn = 0; dmi_req_valid = 0; dmi_req_addr = 0; dmi_req_op = 0; dmi_req_wdata = 0;
        system_bus_read_data = 0; system_bus_read_data_valid = 0;
        sbbusy = 0; sberror = 0; sbbusyerror = 0;
        model_reset();
        test_reset();
        test_sbcs_read();
        test_sbaddress_write();
        test_read_capture_autoinc();
        test_busy_gating();
        test_wrap();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sb_ctrl_regs.md
Name: sb_ctrl_regs

Overview:
- Upstream stage of the debug module's system bus access engine.
- Decodes DMI requests to the System Bus registers sbcs (0x38), sbaddress0 (0x39) and sbdata0 (0x3C), and holds the architectural register state.
- Generates the single-cycle update/read/clear strobes and the static controls the bus engine consumes.
- Captures returned bus read data and performs sbautoincrement after each completed access.

Parameters:
- SBASIZE, 32, sbcs.sbasize field value (bus address width).
- SB_ADDR_BASE, 7'h38, DMI address of sbcs; sbaddress0 = base+1, sbdata0 = base+4.

Ports:
- sys_clk  in  1  debug module clock.
- sys_rstn  in  1  reset, synchronous, active-low.
- dmi_req_valid  in  1  DMI request strobe, one cycle.
- dmi_req_addr  in  7  DMI register address.
- dmi_req_op  in  2  1 = read, 2 = write; 0/3 = no-op.
- dmi_req_wdata  in  32  DMI write data.
- dmi_rsp_valid  out  1  response strobe for a decoded sb register.
- dmi_rsp_rdata  out  32  response data.
- sbaddress0  out  32  current sbaddress0.
- sbaddress0_update  out  1  pulse: DMI wrote sbaddress0.
- sbdata0  out  32  current sbdata0.
- sbdata0_update  out  1  pulse: DMI wrote sbdata0.
- sbdata0_rd  out  1  pulse: DMI read sbdata0 with sbreadondata=1.
- sbreadonaddr  out  1  sbcs[20].
- sbaccess  out  3  sbcs[19:17].
- sbreadondata  out  1  sbcs[15].
- sberror_w1  out  3  pulse: W1C bits for sberror.
- sbbusyerror_w1  out  1  pulse: W1C for sbbusyerror.
- system_bus_read_data  in  32  read data from bus engine.
- system_bus_read_data_valid  in  1  read data qualifier.
- sbbusy  in  1  bus engine busy.
- sberror  in  3  bus engine error code.
- sbbusyerror  in  1  bus engine busy-error flag.

Behaviour:
- Synchronous reset, checked on the sys_clk edge only. Reset values: sbaddress0 = 0, sbdata0 = 0, sbreadonaddr = 0, sbaccess = 3'd2, sbautoincrement = 0, sbreadondata = 0. All strobes and dmi_rsp_valid = 0; dmi_rsp_rdata = 0.
- Reset asserted mid-access clears all local state. Any capture pending in that cycle is dropped.
- Decode: hit = dmi_req_valid && addr ∈ {base, base+1, base+4} && op ∈ {1, 2}. Non-hits produce no response and no side effect.
- Response latency: dmi_rsp_valid pulses exactly 1 cycle after a hit (read or write).
  - Read rdata = register value in the request cycle, before any same-cycle update.
  - Write rdata = 0.
- sbcs read value:
  - [31:29] = 3'd1; [22] = sbbusyerror; [21] = sbbusy; [20] = sbreadonaddr; [19:17] = sbaccess; [16] = sbautoincrement; [15] = sbreadondata; [14:12] = sberror.
  - [11:5] = SBASIZE; [4:0] = 5'b00111 (8/16/32-bit supported); all other bits 0.
- sbcs write:
  - Loads bits 20, 19:17, 16, 15.
  - sberror_w1 = wdata[14:12] and sbbusyerror_w1 = wdata[22], both for one cycle, registered (asserted the cycle after the request).
- Strobes: sbaddress0_update, sbdata0_update and sbdata0_rd are registered and assert the cycle after the hit, for one cycle.
- sbaddress0/sbdata0 writes and sbdata0 reads:
  - Strobes are emitted regardless of sbbusy, so the engine can raise sbbusyerror.
  - The register is loaded only if sbbusy=0 && sbbusyerror=0 && sberror=0; otherwise the write data is discarded.
  - sbdata0_rd also requires that gate.
- Read capture: system_bus_read_data_valid=1 loads sbdata0 from system_bus_read_data next cycle. This has priority over a DMI sbdata0 write in the same cycle (that write is gated by sbbusy anyway).
- Autoincrement:
  - Track sbbusy_d; an access completes when sbbusy_d=1 && sbbusy=0.
  - On completion with sbautoincrement=1 and sberror=0: sbaddress0 += (1 << sbaccess), modulo 2^32 (wraps 0xFFFFFFFC → 0x0).
  - A DMI sbaddress0 write accepted in the same cycle wins over the increment.
- sbaccess > 2 is stored as written. Rejection is the bus engine's job via sberror = 4.

Test Plan:
- Reset, then read 0x38 → rsp 1 cycle later, rdata = 0x20040407 (version 1, sbaccess 2, sbasize 32, access 8/16/32).
- Write 0x39 = 0x1000 with sbbusy=0 → sbaddress0 = 0x1000; sbaddress0_update pulses once, 1 cycle later; rsp rdata = 0.
- sbcs = sbreadondata|sbautoincrement|sbaccess=2; bus returns 0xDEADBEEF (valid=1) then sbbusy falls → sbdata0 = 0xDEADBEEF, sbaddress0 = 0x1004. Read 0x3C → rdata 0xDEADBEEF and sbdata0_rd pulses.
- sbbusy=1, write 0x3C = 0x55 → sbdata0_update pulses, sbdata0 unchanged. Write sbcs bit22=1 → sbbusyerror_w1 pulses.
- sbaccess=0, autoincrement, sbaddress0 = 0xFFFFFFFF, one completed access → sbaddress0 = 0x0.
- Assert sys_rstn=0 while sbbusy=1 and read data valid → next edge all outputs at reset values; no capture into sbdata0.
